// File: rtl/ym3438_slot_sched_if.sv
// Register write bus into the YM3438 slot scheduler: one-MCLK strobe, address, data.
interface ym3438_slot_sched_if;
   logic       wr_en;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;

   modport master (output wr_en, output wr_addr, output wr_data);
   modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/ym3438_slot_sched.sv
// YM3438 c1/c2 phase generator, 24-slot sequencer and reg 0x21/0x22 holding.
// Define LFO_REG_STAGE_EN to defer register writes to the next sample boundary.
module ym3438_slot_sched #(
   parameter int PRESCALE = 6,
   parameter int SLOTS    = 24
) (
   input  logic                MCLK,
   input  logic                IC,
   ym3438_slot_sched_if.slave  wr,
   output logic                c1,
   output logic                c2,
   output logic                fsm_sel0,
   output logic                fsm_sel23,
   output logic [4:0]          slot,
   output logic [2:0]          slot_ch,
   output logic [1:0]          slot_op,
   output logic                sample_tick,
   output logic [7:0]          reg_21,
   output logic [3:0]          lfo,
   output logic                pending
);

   localparam logic [3:0] PRE_LAST  = 4'(PRESCALE - 1);
   localparam logic [3:0] C2_FIRST  = 4'(PRESCALE / 2);
   localparam logic [3:0] C2_SECOND = 4'(PRESCALE / 2 + 1);
   localparam logic [4:0] SLOT_LAST = 5'(SLOTS - 1);

   logic [3:0] pre;
   logic       pre_last;
   logic       boundary;
   logic       wr_21;
   logic       wr_22;

   assign pre_last = (pre == PRE_LAST);
   assign boundary = pre_last && (slot == SLOT_LAST);
   assign wr_21    = wr.wr_en && (wr.wr_addr == 8'h21);
   assign wr_22    = wr.wr_en && (wr.wr_addr == 8'h22);

   always_ff @(posedge MCLK) begin
      if (!IC) begin
         pre         <= 4'd0;
         slot        <= 5'd0;
         sample_tick <= 1'b0;
      end else begin
         pre         <= pre_last ? 4'd0 : pre + 4'd1;
         sample_tick <= boundary;
         if (pre_last)
            slot <= (slot == SLOT_LAST) ? 5'd0 : slot + 5'd1;
      end
   end

   // Phase enables and slot decodes come straight off the registered counters.
   assign c1        = (pre <= 4'd1);
   assign c2        = (pre == C2_FIRST) || (pre == C2_SECOND);
   assign fsm_sel0  = (slot == 5'd0);
   assign fsm_sel23 = (slot == SLOT_LAST);

   always_comb begin
      slot_ch = 3'd0;
      case (slot)
         5'd1, 5'd7,  5'd13, 5'd19: slot_ch = 3'd1;
         5'd2, 5'd8,  5'd14, 5'd20: slot_ch = 3'd2;
         5'd3, 5'd9,  5'd15, 5'd21: slot_ch = 3'd4;
         5'd4, 5'd10, 5'd16, 5'd22: slot_ch = 3'd5;
         5'd5, 5'd11, 5'd17, 5'd23: slot_ch = 3'd6;
         default:                   slot_ch = 3'd0;
      endcase
   end

   always_comb begin
      slot_op = 2'd3;
      if (slot < 5'd6)
         slot_op = 2'd0;
      else if (slot < 5'd12)
         slot_op = 2'd2;
      else if (slot < 5'd18)
         slot_op = 2'd1;
   end

`ifdef LFO_REG_STAGE_EN
   typedef enum logic {IDLE, ARMED} state_t;

   state_t     state;
   logic [7:0] stage21;
   logic [3:0] stage22;
   logic       p21;
   logic       p22;

   // A write landing on the boundary edge is staged after the commit, so it waits a full sample.
   always_ff @(posedge MCLK) begin
      if (!IC) begin
         reg_21  <= 8'h00;
         lfo     <= 4'h0;
         stage21 <= 8'h00;
         stage22 <= 4'h0;
         p21     <= 1'b0;
         p22     <= 1'b0;
      end else begin
         if (boundary) begin
            if (p21) reg_21 <= stage21;
            if (p22) lfo    <= stage22;
         end
         if (wr_21) stage21 <= wr.wr_data;
         if (wr_22) stage22 <= wr.wr_data[3:0];
         p21 <= wr_21 || (p21 && !boundary);
         p22 <= wr_22 || (p22 && !boundary);
      end
   end

   always_ff @(posedge MCLK) begin
      if (!IC) begin
         state   <= IDLE;
         pending <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (wr_21 || wr_22) begin
                  state   <= ARMED;
                  pending <= 1'b1;
               end
            end
            ARMED: begin
               if (boundary && !(wr_21 || wr_22)) begin
                  state   <= IDLE;
                  pending <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               pending <= 1'b0;
            end
         endcase
      end
   end
`else
   always_ff @(posedge MCLK) begin
      if (!IC) begin
         reg_21 <= 8'h00;
         lfo    <= 4'h0;
      end else begin
         if (wr_21) reg_21 <= wr.wr_data;
         if (wr_22) lfo    <= wr.wr_data[3:0];
      end
   end

   assign pending = 1'b0;
`endif

endmodule

// File: doc/ym3438_slot_sched.md
Name: ym3438_slot_sched

Overview:
- Timing and register-staging controller for the LFO/phase-modulation datapath.
- Divides MCLK into the c1/c2 phase enables.
- Runs the 24-slot sample sequencer and emits fsm_sel0/fsm_sel23, channel and operator indices.
- Holds regs 0x21 (test) and 0x22 (LFO enable/rate); writes commit only at sample boundaries, so LFO rate and enable never change mid-sample.

Parameters:
PRESCALE, 6, MCLK cycles per c1/c2 phase cycle (legal 4..15)
SLOTS, 24, slots per sample (fixed operator order requires 24)

Ports:
MCLK  in  1  master clock, all state on rising edge
IC  in  1  synchronous active-low reset (initial clear)
wr_en  in  1  register write strobe, one MCLK wide
wr_addr  in  8  register address; only 0x21, 0x22 decoded
wr_data  in  8  register write data
c1  out  1  phase-1 enable
c2  out  1  phase-2 enable
fsm_sel0  out  1  high during slot 0
fsm_sel23  out  1  high during slot 23
slot  out  5  current slot 0..23
slot_ch  out  3  channel code 0,1,2,4,5,6 (3 skipped)
slot_op  out  2  operator code in order 0,2,1,3
sample_tick  out  1  one-MCLK pulse on the slot 23->0 transition
reg_21  out  8  committed test register
lfo  out  4  committed {enable, rate[2:0]} from reg 0x22 bits [3:0]
pending  out  1  uncommitted write is held

Behaviour:
- Reset (IC=0 at a MCLK edge):
  - pre=0, slot=0.
  - reg_21=0x00, lfo=0x0; staging registers cleared; pending=0, sample_tick=0.
  - c1=1, c2=0 (pre=0 decode); fsm_sel0=1, fsm_sel23=0, slot_ch=0, slot_op=0.
  - A write coincident with IC=0 is dropped.
- Prescaler: pre counts 0..PRESCALE-1 and wraps.
  - c1 = (pre<=1).
  - c2 = (pre==PRESCALE/2 or PRESCALE/2+1).
  - c1 and c2 are never high together.
- Slot counter: advances on the MCLK edge where pre==PRESCALE-1; 23 wraps to 0. Slot is constant for exactly PRESCALE MCLK cycles.
- Decodes (combinational from registered slot, zero latency):
  - fsm_sel0 = (slot==0); fsm_sel23 = (slot==23).
  - slot_ch = {0,1,2,4,5,6}[slot mod 6].
  - slot_op = {0,2,1,3}[slot div 6].
- sample_tick is registered; it is high the first MCLK of slot 0 after a wrap, never after reset.
- Writes (wr_en=1, IC=1):
  - addr 0x21 loads stage21, sets p21. addr 0x22 loads stage22 (bits[3:0]), sets p22.
  - Other addresses are ignored. Repeated writes before commit: last wins.
- Commit:
  - On the slot-wrap edge (slot 23, pre==PRESCALE-1): reg_21<=stage21 if p21; lfo<=stage22 if p22; p21, p22 clear.
  - A write on the same edge as commit is not included. It goes to staging and commits at the next boundary, with pending staying 1.
- pending = p21|p22 (registered).
- Commit state machine:
  - IDLE: nothing pending.
  - ARMED: write pending. Goes to IDLE at the boundary, or stays ARMED if there is a same-edge write.
  - IC=0 forces IDLE.
- Reset mid-sample: counters restart at slot 0/pre 0 next edge; staged writes are discarded.
- All outputs are registered or decoded from registers; no combinational path from wr_* to outputs.

Optional Feature:
- Macro: LFO_REG_STAGE_EN.
- Defined: sample-boundary staging as above.
- Undefined:
  - Writes to 0x21/0x22 update reg_21/lfo on the next MCLK edge.
  - Staging registers are removed; pending is tied 0.
  - All counter and decode behaviour is unchanged.

Test Plan:
- Release IC after 3 cycles -> c1 high for pre 0,1; c2 for pre 3,4; slot increments every 6 MCLK; fsm_sel23 high for 6 MCLK at slot 23; sample_tick period 144 MCLK.
- Step slots 0..23 -> slot_ch sequence 0,1,2,4,5,6 repeating; slot_op 0 (slots 0-5), 2, 1, 3 (18-23).
- Write 0x22=0x0B at slot 5 -> pending=1, lfo stays 0x0; after the slot 23->0 edge lfo=0xB, pending=0.
- Write 0x22=0x09 then 0x22=0x0C within one sample -> lfo=0xC at boundary; write 0x21=0x02 on the exact commit edge -> reg_21 unchanged, pending=1, reg_21=0x02 one sample (144 MCLK) later.
- Write 0x21=0xFF, assert IC at slot 10 -> reg_21=0x00, pending=0, slot=0, fsm_sel0=1; no commit after release.
- Without LFO_REG_STAGE_EN: write 0x22=0x0F at slot 7 -> lfo=0xF next MCLK; pending always 0.
